// File: rtl/commit_obsv_tx_pkg.sv
// Shared definitions for the commit-observation transmit path: field widths, FSM encoding, record width.
// Build option: OBSV_LD_DATA_EN adds the per-record load-result field.
`ifndef ROB_SIZE_LOG
`define ROB_SIZE_LOG 4
`endif
`ifndef MEMD_SIZE_LOG
`define MEMD_SIZE_LOG 8
`endif
// Packed record: {[ld_data], mem_valid, mem_rdwt, mem_addr, seq, last}
`define OBSV_REC_W(MEMD_W, SEQ_W, DATA_W) ((MEMD_W) + (SEQ_W) + (DATA_W) + 3)

package commit_obsv_tx_pkg;
    localparam int ROB_SIZE_LOG_DEF  = `ROB_SIZE_LOG;
    localparam int MEMD_SIZE_LOG_DEF = `MEMD_SIZE_LOG;
    localparam int SEQ_W_DEF         = 8;
    localparam int DATA_W_DEF        = 8;
`ifdef OBSV_LD_DATA_EN
    localparam bit LD_DATA_EN = 1'b1;
`else
    localparam bit LD_DATA_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } obsv_state_e;
endpackage

// File: rtl/commit_obsv_tx_obsv_rec_fifo.sv
// Record FIFO: registered storage, head read straight from the array, count/full/empty flags.
module obsv_rec_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;
    logic          wr_en, rd_en;

    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign empty = (cnt_q == '0);
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;
    assign count = cnt_q;
    assign rdata = mem_q[rptr_q];

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr_en) wptr_q <= wptr_q + 1'b1;
            if (rd_en) rptr_q <= rptr_q + 1'b1;
            if (wr_en && !rd_en)      cnt_q <= cnt_q + 1'b1;
            else if (rd_en && !wr_en) cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q] <= wdata;
    end
endmodule

// File: rtl/commit_obsv_tx.sv
// Commit-observation transmitter: seq numbering, record FIFO, stall request and ROB-drain FSM.
// Build option: OBSV_LD_DATA_EN adds c_rd_data / tx_rd_data.
module commit_obsv_tx
    import commit_obsv_tx_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int ROB_SIZE_LOG  = ROB_SIZE_LOG_DEF,
    parameter int MEMD_SIZE_LOG = MEMD_SIZE_LOG_DEF,
    parameter int SEQ_W         = SEQ_W_DEF,
    parameter int DATA_W        = DATA_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     c_valid,
    input  logic                     c_mem_valid,
    input  logic                     c_mem_rdwt,
    input  logic [MEMD_SIZE_LOG-1:0] c_mem_addr,
    input  logic                     c_squash,
    input  logic [ROB_SIZE_LOG-1:0]  rob_head,
    input  logic [ROB_SIZE_LOG-1:0]  rob_tail,
    input  logic                     drain_req,
`ifdef OBSV_LD_DATA_EN
    input  logic [DATA_W-1:0]        c_rd_data,
    output logic [DATA_W-1:0]        tx_rd_data,
`endif
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic                     tx_mem_valid,
    output logic                     tx_mem_rdwt,
    output logic [MEMD_SIZE_LOG-1:0] tx_mem_addr,
    output logic [SEQ_W-1:0]         tx_seq,
    output logic                     tx_last,
    output logic                     cpu_stall,
    output logic                     drain_done
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int DW    = LD_DATA_EN ? DATA_W : 0;
    localparam int REC_W = `OBSV_REC_W(MEMD_SIZE_LOG, SEQ_W, DW);
    localparam int A_LO  = SEQ_W + 1;
    localparam int A_HI  = SEQ_W + MEMD_SIZE_LOG;

    obsv_state_e             state_q;
    logic [SEQ_W-1:0]        seq_q;
    logic [ROB_SIZE_LOG-1:0] tail_snap_q, tail_m1;
    logic                    drain_done_q;
    logic                    push, pop, tag_last, full, empty;
    logic [AW:0]             count;
    logic [REC_W-1:0]        wdata, rdata;

    assign tail_m1  = tail_snap_q - 1'b1;
    assign tag_last = (state_q == ST_DRAIN) && (c_squash || rob_head == tail_m1);
    assign push     = c_valid && !full && (state_q != ST_DONE);
    assign pop      = tx_valid && tx_ready;

    // DONE freezes the copy for good; otherwise stall only while the FIFO is full
    assign cpu_stall  = (count == (AW+1)'(FIFO_DEPTH)) || (state_q == ST_DONE);
    assign drain_done = drain_done_q;

`ifdef OBSV_LD_DATA_EN
    logic [DATA_W-1:0] ld_data;
    assign ld_data    = (c_mem_valid && c_mem_rdwt) ? c_rd_data : '0;
    assign wdata      = {ld_data, c_mem_valid, c_mem_rdwt, c_mem_addr, seq_q, tag_last};
    assign tx_rd_data = tx_valid ? rdata[REC_W-1 -: DATA_W] : '0;
`else
    assign wdata      = {c_mem_valid, c_mem_rdwt, c_mem_addr, seq_q, tag_last};
`endif

    obsv_rec_fifo #(.W(REC_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign tx_valid     = !empty;
    assign tx_last      = tx_valid & rdata[0];
    assign tx_seq       = tx_valid ? rdata[SEQ_W:1] : '0;
    assign tx_mem_addr  = tx_valid ? rdata[A_HI:A_LO] : '0;
    assign tx_mem_rdwt  = tx_valid & rdata[A_HI+1];
    assign tx_mem_valid = tx_valid & rdata[A_HI+2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_RUN;
            seq_q        <= '0;
            tail_snap_q  <= '0;
            drain_done_q <= 1'b0;
        end else begin
            if (push)           seq_q        <= seq_q + 1'b1;
            if (pop && rdata[0]) drain_done_q <= 1'b1;
            case (state_q)
                ST_RUN: begin
                    if (drain_req) begin
                        tail_snap_q <= rob_tail;
                        state_q     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (push && tag_last) state_q <= ST_DONE;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_commit_obsv_tx.sv
// Randomized and directed bench for commit_obsv_tx against a queue-based reference model.
module tb_commit_obsv_tx;
    import commit_obsv_tx_pkg::*;

    localparam int DEPTH = 4;
    localparam int R     = ROB_SIZE_LOG_DEF;
    localparam int M     = MEMD_SIZE_LOG_DEF;
    localparam int S     = 8;
    localparam int D     = 8;

    logic         clk = 1'b0, rst = 1'b1;
    logic         c_valid = 0, c_mem_valid = 0, c_mem_rdwt = 0, c_squash = 0, drain_req = 0, tx_ready = 0;
    logic [M-1:0] c_mem_addr = '0;
    logic [R-1:0] rob_head = '0, rob_tail = '0;
    logic [D-1:0] c_rd_data = '0;
    logic         tx_valid, tx_mem_valid, tx_mem_rdwt, tx_last, cpu_stall, drain_done;
    logic [M-1:0] tx_mem_addr;
    logic [S-1:0] tx_seq;
`ifdef OBSV_LD_DATA_EN
    logic [D-1:0] tx_rd_data;
`endif

    always #5 clk = ~clk;

    commit_obsv_tx #(.FIFO_DEPTH(DEPTH), .ROB_SIZE_LOG(R), .MEMD_SIZE_LOG(M), .SEQ_W(S), .DATA_W(D)) dut (
        .clk(clk), .rst(rst), .c_valid(c_valid), .c_mem_valid(c_mem_valid), .c_mem_rdwt(c_mem_rdwt),
        .c_mem_addr(c_mem_addr), .c_squash(c_squash), .rob_head(rob_head), .rob_tail(rob_tail),
        .drain_req(drain_req),
`ifdef OBSV_LD_DATA_EN
        .c_rd_data(c_rd_data), .tx_rd_data(tx_rd_data),
`endif
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_mem_valid(tx_mem_valid), .tx_mem_rdwt(tx_mem_rdwt),
        .tx_mem_addr(tx_mem_addr), .tx_seq(tx_seq), .tx_last(tx_last), .cpu_stall(cpu_stall),
        .drain_done(drain_done)
    );

    typedef struct {
        bit          mv, rw, last;
        int unsigned addr, seq, data;
    } rec_t;

    rec_t        q[$];
    int unsigned m_seq;
    bit          m_drain, m_done, m_dd;
    logic [R-1:0] m_snap;
    int          n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_seq = 0; m_drain = 0; m_done = 0; m_dd = 0; m_snap = '0;
    endtask

    task automatic check_out();
        chk("tx_valid", tx_valid, q.size() != 0);
        chk("cpu_stall", cpu_stall, (q.size() == DEPTH) || m_done);
        chk("drain_done", drain_done, m_dd);
        if (q.size() != 0) begin
            chk("tx_seq", tx_seq, q[0].seq);
            chk("tx_last", tx_last, q[0].last);
            chk("tx_mem_valid", tx_mem_valid, q[0].mv);
            chk("tx_mem_rdwt", tx_mem_rdwt, q[0].rw);
            chk("tx_mem_addr", tx_mem_addr, q[0].addr);
`ifdef OBSV_LD_DATA_EN
            chk("tx_rd_data", tx_rd_data, q[0].data);
`endif
        end else begin
            chk("idle_fields", {tx_seq, tx_mem_addr, tx_last, tx_mem_valid, tx_mem_rdwt}, 0);
        end
    endtask

    // Called at a negedge; drives one cycle of inputs, advances the model, checks at next negedge
    task automatic step(input bit v, input bit sq, input logic [R-1:0] hd, input logic [R-1:0] tl,
                        input bit dq, input bit rdy);
        rec_t r;
        bit stall, push, pop, run;
        logic [R-1:0] snap_m1;
        c_valid = v; c_squash = sq; rob_head = hd; rob_tail = tl; drain_req = dq; tx_ready = rdy;
        c_mem_valid = 1'($urandom); c_mem_rdwt = 1'($urandom);
        c_mem_addr = M'($urandom); c_rd_data = D'($urandom);
        stall   = (q.size() == DEPTH) || m_done;
        run     = !m_drain && !m_done;
        pop     = (q.size() != 0) && rdy;
        push    = v && !stall;
        snap_m1 = m_snap - 1'b1;
        if (pop) begin
            r = q.pop_front();
            if (r.last) m_dd = 1;
        end
        if (push) begin
            r.mv = c_mem_valid; r.rw = c_mem_rdwt; r.addr = c_mem_addr;
            r.data = (c_mem_valid && c_mem_rdwt) ? c_rd_data : 0;
            r.seq  = m_seq;
            r.last = m_drain && (sq || hd == snap_m1);
            q.push_back(r);
            m_seq = (m_seq + 1) % (1 << S);
            if (r.last) begin m_drain = 0; m_done = 1; end
        end
        if (run && dq) begin m_drain = 1; m_snap = tl; end
        @(negedge clk);
        check_out();
    endtask

    task automatic async_reset();
        rst = 1'b0;
        #1;
        chk("rst_valid", tx_valid, 0);
        chk("rst_stall", cpu_stall, 0);
        chk("rst_done", drain_done, 0);
        chk("rst_fields", {tx_seq, tx_last, tx_mem_valid}, 0);
        model_reset();
        c_valid = 0; drain_req = 0; tx_ready = 0; c_squash = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #2 async_reset();

        // Back-to-back commits, latency one
        step(1, 0, 0, 0, 0, 1);
        chk("first_seq", tx_seq, 0);
        step(1, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1);
        chk("third_seq", tx_seq, 2);
        repeat (2) step(0, 0, 0, 0, 0, 1);

        // Fill to full with ready low, hold the 5th commit
        async_reset();
        repeat (5) step(1, 0, 0, 0, 0, 0);
        chk("stall_full", cpu_stall, 1);
        step(1, 0, 0, 0, 0, 1);
        chk("stall_drop", cpu_stall, 0);
        repeat (6) step(0, 0, 0, 0, 0, 1);

        // Sequence wrap
        async_reset();
        repeat (257) step(1, 0, 0, 0, 0, 1);
        repeat (3) step(0, 0, 0, 0, 0, 1);

        // Drain ended by reaching the tail snapshot
        async_reset();
        step(0, 0, 0, 5, 1, 1);
        step(1, 0, 2, 0, 0, 1);
        step(1, 0, 3, 0, 1, 1);
        step(1, 0, 4, 0, 0, 1);
        chk("drain_last", tx_last, 1);
        repeat (4) step(1, 0, 5, 0, 0, 1);
        chk("drain_done_set", drain_done, 1);

        // Drain ended by squash; later commits ignored
        async_reset();
        step(0, 0, 0, 6, 1, 0);
        step(1, 1, 1, 0, 0, 0);
        repeat (4) step(1, 0, 2, 0, 0, 0);
        chk("squash_cnt", q.size(), 1);
        repeat (3) step(1, 0, 2, 0, 0, 1);

        // Async reset mid-drain with records queued
        async_reset();
        step(0, 0, 0, 9, 1, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        step(1, 0, 2, 0, 0, 0);
        #2 async_reset();
        step(1, 0, 0, 0, 0, 1);
        chk("post_rst_seq", tx_seq, 0);

        // Random episodes
        for (int ep = 0; ep < 6; ep++) begin
            async_reset();
            for (int i = 0; i < 150; i++)
                step(($urandom % 4) != 0, ($urandom % 16) == 0, R'($urandom), R'($urandom),
                     ($urandom % 20) == 0, ($urandom % 3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
